count_seq_checker: RTL and testbench

- Receive-side monitor for the free-running W-bit synchronous up-counter bus.
- Samples the counter's `count` output every clock and checks that it advances by exactly +1 modulo 2^W.
- Acquires lock, flags and tallies sequence errors, and counts wrap-arounds.
- Sits at the consumer end of the count bus, in the same clock domain as the counter, and gives the counter a self-checking partner in system benches.

---
 rtl/count_seq_checker.sv | 166 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// count_seq_checker
//
// Receive-side monitor for a free-running W-bit up-counter bus. Every clock
// it samples count_in and checks that the bus advanced by exactly +1 modulo
// 2^W. It acquires lock after LOCK_LEN consecutive correct steps. While
// locked it flags and tallies sequence errors and counts legal wrap-arounds.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   count_in    count bus from the counter under observation (W bits)
//   check_en    enable checking; low forces the UNLOCKED state
//   locked      high while in the LOCKED state
//   err_pulse   one-cycle pulse per sequence error seen while LOCKED
//   err_count   saturating tally of errors seen while LOCKED (EW bits)
//   wrap_count  saturating tally of all-ones -> zero steps while LOCKED (EW bits)
//   expected    value expected at the next sampling edge (ref + 1 mod 2^W)
//
// All outputs come straight from flops.

module count_seq_checker #(
  parameter int W          = 4,
  parameter int LOCK_LEN   = 3,
  parameter int EW         = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  count_in,
  input  logic          check_en,
  output logic          locked,
  output logic          err_pulse,
  output logic [EW-1:0] err_count,
  output logic [EW-1:0] wrap_count,
  output logic [W-1:0]  expected
);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

  state_t        state_q, state_d;
  logic [W-1:0]  ref_q, ref_d;
  logic [3:0]    run_q, run_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic [EW-1:0] err_count_q, err_count_d;
  logic [EW-1:0] wrap_count_q, wrap_count_d;
  logic [W-1:0]  expected_q, expected_d;

  logic       stepOk;
  logic       holdOk;
  logic       wrapHit;
  logic [3:0] runInc;

  // expected_q always holds ref_q + 1, so it doubles as the comparison
  // value for the +1 check and keeps the adder off the compare path.
  // A hold is only legal when it is not also a +1 step, which for any
  // W >= 1 it never is.
  always_comb begin
    stepOk  = (count_in == expected_q);
    holdOk  = (ALLOW_HOLD != 0) && (count_in == ref_q);
    wrapHit = (&ref_q) && (count_in == '0);
    runInc  = run_q + 4'd1;
  end

  // Next-state logic. check_en low takes priority over everything, so a
  // mismatch on the same edge as a disable is never reported. The tallies
  // are only ever cleared by rst and saturate at all-ones.
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    run_d        = run_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (!check_en) begin
      state_d  = UNLOCKED;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          ref_d   = count_in;
          run_d   = 4'd0;
          state_d = ACQUIRE;
        end

        ACQUIRE: begin
          if (stepOk) begin
            ref_d = count_in;
            run_d = runInc;
            if (runInc == LOCK_RUN) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (!holdOk) begin
            // Resync silently: errors only count once the sequence is trusted.
            ref_d = count_in;
            run_d = 4'd0;
          end
        end

        LOCKED: begin
          if (stepOk) begin
            ref_d = count_in;
            if (wrapHit && !(&wrap_count_q)) begin
              wrap_count_d = wrap_count_q + 1'b1;
            end
          end else if (!holdOk) begin
            err_pulse_d = 1'b1;
            if (!(&err_count_q)) begin
              err_count_d = err_count_q + 1'b1;
            end
            ref_d    = count_in;
            run_d    = 4'd0;
            state_d  = ACQUIRE;
            locked_d = 1'b0;
          end
        end

        default: begin
          state_d  = UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end

    expected_d = ref_d + W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      ref_q        <= '0;
      run_q        <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      expected_q   <= W'(1);
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      expected_q   <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//
// Drives three count_seq_checker instances from directed vectors:
//   d0: defaults (W=4, LOCK_LEN=3, EW=8, ALLOW_HOLD=0)
//   d1: ALLOW_HOLD=1
//   d2: EW=2, for tally saturation
// Each stimulus step pushes the hand-computed register contents expected
// after the next rising edge into a per-instance queue. A monitor per
// instance pops and compares shortly after every rising edge.

module tb_count_seq_checker;

  typedef struct {
    int lk;
    int ep;
    int ec;
    int wc;
    int ex;
  } expect_t;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] count0, count1, count2;
  logic       en0, en1, en2;

  logic       locked0, locked1, locked2;
  logic       errPulse0, errPulse1, errPulse2;
  logic [7:0] errCount0, errCount1;
  logic [7:0] wrapCount0, wrapCount1;
  logic [1:0] errCount2, wrapCount2;
  logic [3:0] expected0, expected1, expected2;

  expect_t q0[$];
  expect_t q1[$];
  expect_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.W(4), .LOCK_LEN(3), .EW(8), .ALLOW_HOLD(0)) d0 (
    .clk(clk), .rst(rst), .count_in(count0), .check_en(en0),
    .locked(locked0), .err_pulse(errPulse0), .err_count(errCount0),
    .wrap_count(wrapCount0), .expected(expected0)
  );

  count_seq_checker #(.W(4), .LOCK_LEN(3), .EW(8), .ALLOW_HOLD(1)) d1 (
    .clk(clk), .rst(rst), .count_in(count1), .check_en(en1),
    .locked(locked1), .err_pulse(errPulse1), .err_count(errCount1),
    .wrap_count(wrapCount1), .expected(expected1)
  );

  count_seq_checker #(.W(4), .LOCK_LEN(3), .EW(2), .ALLOW_HOLD(0)) d2 (
    .clk(clk), .rst(rst), .count_in(count2), .check_en(en2),
    .locked(locked2), .err_pulse(errPulse2), .err_count(errCount2),
    .wrap_count(wrapCount2), .expected(expected2)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one sample at the falling edge; the DUT takes it at the next
  // rising edge and the expectation describes the outputs right after it.
  task automatic applyStimulus(input int dut, input int cnt, input logic en,
                               input int lk, input int ep, input int ec,
                               input int wc, input int ex);
    expect_t e;
    e.lk = lk; e.ep = ep; e.ec = ec; e.wc = wc; e.ex = ex;
    @(negedge clk);
    case (dut)
      0: begin count0 = 4'(cnt); en0 = en; q0.push_back(e); end
      1: begin count1 = 4'(cnt); en1 = en; q1.push_back(e); end
      default: begin count2 = 4'(cnt); en2 = en; q2.push_back(e); end
    endcase
  endtask

  // Monitors: one per instance, each comparing after every rising edge.
  initial begin : mon0
    expect_t e;
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput($sformatf("d0#%0d locked", n), int'(locked0), e.lk);
        checkOutput($sformatf("d0#%0d err_pulse", n), int'(errPulse0), e.ep);
        checkOutput($sformatf("d0#%0d err_count", n), int'(errCount0), e.ec);
        checkOutput($sformatf("d0#%0d wrap_count", n), int'(wrapCount0), e.wc);
        checkOutput($sformatf("d0#%0d expected", n), int'(expected0), e.ex);
        n++;
      end
    end
  end

  initial begin : mon1
    expect_t e;
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput($sformatf("d1#%0d locked", n), int'(locked1), e.lk);
        checkOutput($sformatf("d1#%0d err_pulse", n), int'(errPulse1), e.ep);
        checkOutput($sformatf("d1#%0d err_count", n), int'(errCount1), e.ec);
        checkOutput($sformatf("d1#%0d wrap_count", n), int'(wrapCount1), e.wc);
        checkOutput($sformatf("d1#%0d expected", n), int'(expected1), e.ex);
        n++;
      end
    end
  end

  initial begin : mon2
    expect_t e;
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q2.size() > 0) begin
        e = q2.pop_front();
        checkOutput($sformatf("d2#%0d locked", n), int'(locked2), e.lk);
        checkOutput($sformatf("d2#%0d err_pulse", n), int'(errPulse2), e.ep);
        checkOutput($sformatf("d2#%0d err_count", n), int'(errCount2), e.ec);
        checkOutput($sformatf("d2#%0d wrap_count", n), int'(wrapCount2), e.wc);
        checkOutput($sformatf("d2#%0d expected", n), int'(expected2), e.ex);
        n++;
      end
    end
  end

  initial begin : stim
    int r;
    int b;
    int v;
    int sat;

    rst = 1'b1;
    count0 = '0; count1 = '0; count2 = '0;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset locked", int'(locked0), 0);
    checkOutput("reset err_pulse", int'(errPulse0), 0);
    checkOutput("reset err_count", int'(errCount0), 0);
    checkOutput("reset wrap_count", int'(wrapCount0), 0);
    checkOutput("reset expected", int'(expected0), 1);
    rst = 1'b0;

    $display("[TB] d0: acquisition, wrap, skip error, hold error");
    applyStimulus(0, 0, 1'b1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1'b1, 0, 0, 0, 0, 2);
    applyStimulus(0, 2, 1'b1, 0, 0, 0, 0, 3);
    applyStimulus(0, 3, 1'b1, 1, 0, 0, 0, 4);
    for (int i = 4; i <= 15; i++) applyStimulus(0, i, 1'b1, 1, 0, 0, 0, (i + 1) & 15);
    applyStimulus(0, 0, 1'b1, 1, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) applyStimulus(0, i, 1'b1, 1, 0, 0, 1, i + 1);
    applyStimulus(0, 8, 1'b1, 0, 1, 1, 1, 9);
    applyStimulus(0, 9, 1'b1, 0, 0, 1, 1, 10);
    applyStimulus(0, 10, 1'b1, 0, 0, 1, 1, 11);
    applyStimulus(0, 11, 1'b1, 1, 0, 1, 1, 12);
    applyStimulus(0, 12, 1'b1, 1, 0, 1, 1, 13);
    applyStimulus(0, 12, 1'b1, 0, 1, 2, 1, 13);
    applyStimulus(0, 13, 1'b1, 0, 0, 2, 1, 14);
    applyStimulus(0, 14, 1'b1, 0, 0, 2, 1, 15);
    applyStimulus(0, 15, 1'b1, 1, 0, 2, 1, 0);

    $display("[TB] d0: disable on a mismatch edge, reacquire");
    applyStimulus(0, 9, 1'b0, 0, 0, 2, 1, 0);
    applyStimulus(0, 3, 1'b1, 0, 0, 2, 1, 4);
    applyStimulus(0, 4, 1'b1, 0, 0, 2, 1, 5);
    applyStimulus(0, 5, 1'b1, 0, 0, 2, 1, 6);
    applyStimulus(0, 6, 1'b1, 1, 0, 2, 1, 7);

    $display("[TB] d0: asynchronous reset between edges");
    @(posedge clk);
    #3;
    rst = 1'b1;
    en0 = 1'b0;
    #1;
    checkOutput("async locked", int'(locked0), 0);
    checkOutput("async err_pulse", int'(errPulse0), 0);
    checkOutput("async err_count", int'(errCount0), 0);
    checkOutput("async wrap_count", int'(wrapCount0), 0);
    checkOutput("async expected", int'(expected0), 1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] d0: mismatch during acquisition");
    applyStimulus(0, 5, 1'b1, 0, 0, 0, 0, 6);
    applyStimulus(0, 7, 1'b1, 0, 0, 0, 0, 8);
    applyStimulus(0, 8, 1'b1, 0, 0, 0, 0, 9);
    applyStimulus(0, 0, 1'b0, 0, 0, 0, 0, 9);

    $display("[TB] d1: repeated sample with hold allowed");
    applyStimulus(1, 0, 1'b1, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1'b1, 0, 0, 0, 0, 2);
    applyStimulus(1, 2, 1'b1, 0, 0, 0, 0, 3);
    applyStimulus(1, 3, 1'b1, 1, 0, 0, 0, 4);
    applyStimulus(1, 4, 1'b1, 1, 0, 0, 0, 5);
    applyStimulus(1, 4, 1'b1, 1, 0, 0, 0, 5);
    applyStimulus(1, 5, 1'b1, 1, 0, 0, 0, 6);
    applyStimulus(1, 0, 1'b0, 0, 0, 0, 0, 6);

    $display("[TB] d2: error tally saturation");
    applyStimulus(2, 0, 1'b1, 0, 0, 0, 0, 1);
    applyStimulus(2, 1, 1'b1, 0, 0, 0, 0, 2);
    applyStimulus(2, 2, 1'b1, 0, 0, 0, 0, 3);
    applyStimulus(2, 3, 1'b1, 1, 0, 0, 0, 4);
    r = 3;
    for (int k = 0; k < 5; k++) begin
      sat = (k < 3) ? k + 1 : 3;
      b = (r + 2) & 15;
      applyStimulus(2, b, 1'b1, 0, 1, sat, 0, (b + 1) & 15);
      for (int i = 1; i <= 3; i++) begin
        v = (b + i) & 15;
        applyStimulus(2, v, 1'b1, (i == 3) ? 1 : 0, 0, sat, 0, (v + 1) & 15);
      end
      r = (b + 3) & 15;
    end
    applyStimulus(2, 0, 1'b0, 0, 0, 3, 0, (r + 1) & 15);

    // Let the monitors drain, with a bounded wait.
    for (int c = 0; c < 10; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, want 0", q0.size() + q1.size() + q2.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
